// File: rtl/fft_hdmi_fifo_wr_ctrl.sv
// Write-side sequencer for the FFT->HDMI spectrum FIFO: flush, align to the FFT frame start, capture NUM_BINS words.
// Optional peak-hold decimation by DECIM is built only when FFT_FIFO_DECIM_EN is defined.
module fft_hdmi_fifo_wr_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BINS   = 512,
  parameter int RST_CYCLES = 4,
  parameter int DECIM      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_req,
  input  logic [DATA_WIDTH-1:0] fft_data,
  input  logic                  fft_valid,
  input  logic                  fft_last,
  input  logic                  fifo_full,
  input  logic [ADDR_WIDTH:0]   fifo_wr_water_level,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_wr_rst,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  short_frame,
  output logic [15:0]           drop_cnt
);

  localparam int CNT_W = $clog2(NUM_BINS) + 1;
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_ALIGN, S_CAPTURE, S_DONE} state_t;

  state_t                state, state_nx;
  logic [RST_W-1:0]      rst_cnt;
  logic [CNT_W-1:0]      bin_cnt;
  logic                  cap_end;
  logic                  req_ok;
  logic                  accept;
  logic                  issue;
  logic                  last_word;
  logic                  short_hit;
  logic [DATA_WIDTH-1:0] word;
  logic                  unused;

  assign req_ok    = (state == S_IDLE) & frame_req;
  // cap_end blocks beats arriving after the final word of the frame
  assign accept    = (state == S_CAPTURE) & fft_valid & ~cap_end;
  assign last_word = (bin_cnt == CNT_W'(NUM_BINS - 1));

`ifdef FFT_FIFO_DECIM_EN
  localparam int GRP_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [GRP_W-1:0]      grp_cnt;
  logic [DATA_WIDTH-1:0] peak;
  logic                  grp_full;

  assign grp_full  = (grp_cnt == GRP_W'(DECIM - 1));
  assign word      = ((grp_cnt == '0) || (fft_data > peak)) ? fft_data : peak;
  assign issue     = accept & (grp_full | fft_last);
  // a last beat that closes a partial group is short even if it fills the final word
  assign short_hit = fft_last & (~last_word | ~grp_full);
  assign unused    = ^fifo_wr_water_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_cnt <= '0;
      peak    <= '0;
    end else if (state == S_ALIGN) begin
      grp_cnt <= '0;
    end else if (accept) begin
      peak    <= word;
      grp_cnt <= issue ? '0 : grp_cnt + 1'b1;
    end
  end
`else
  assign word      = fft_data;
  assign issue     = accept;
  assign short_hit = fft_last & ~last_word;
  assign unused    = ^{fifo_wr_water_level, DECIM[0]};
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (frame_req) state_nx = S_FLUSH;
      S_FLUSH:   if (rst_cnt == '0) state_nx = S_ALIGN;
      S_ALIGN:   if (fft_valid && fft_last) state_nx = S_CAPTURE;
      S_CAPTURE: if (cap_end) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rst_cnt      <= '0;
      bin_cnt      <= '0;
      cap_end      <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      fifo_wr_rst  <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state       <= state_nx;
      // status outputs decoded from next state so they are glitch-free flops
      fifo_wr_rst <= (state_nx == S_FLUSH);
      busy        <= (state_nx != S_IDLE);
      frame_done  <= (state_nx == S_DONE);
      fifo_wr_en  <= issue;
      if (issue) fifo_wr_data <= word;

      if (req_ok) rst_cnt <= RST_W'(RST_CYCLES - 1);
      else if (state == S_FLUSH && rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;

      if (state == S_ALIGN) begin
        bin_cnt <= '0;
        cap_end <= 1'b0;
      end else if (issue) begin
        bin_cnt <= bin_cnt + 1'b1;
        if (last_word || fft_last) cap_end <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow    <= 1'b0;
      short_frame <= 1'b0;
      drop_cnt    <= '0;
    end else if (req_ok) begin
      overflow    <= 1'b0;
      short_frame <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (issue && short_hit) short_frame <= 1'b1;
      if (fifo_wr_en && fifo_full) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_hdmi_fifo_wr_ctrl.sv
// Table-driven bench for fft_hdmi_fifo_wr_ctrl with NUM_BINS=8, RST_CYCLES=4 (peak-hold vectors if FFT_FIFO_DECIM_EN).
module tb_fft_hdmi_fifo_wr_ctrl;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NB = 8;
  localparam int RC = 4;

  logic          clk, rst_n, frame_req, fft_valid, fft_last, fifo_full;
  logic [DW-1:0] fft_data, fifo_wr_data;
  logic [AW:0]   lvl;
  logic          fifo_wr_en, fifo_wr_rst, busy, frame_done, overflow, short_frame;
  logic [15:0]   drop_cnt;

  fft_hdmi_fifo_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BINS(NB), .RST_CYCLES(RC), .DECIM(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .fft_data(fft_data), .fft_valid(fft_valid),
    .fft_last(fft_last), .fifo_full(fifo_full), .fifo_wr_water_level(lvl), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_rst(fifo_wr_rst), .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .short_frame(short_frame), .drop_cnt(drop_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  int          wr_idx = 0, wr_base = 0;
  logic [31:0] full_mask = '0;
  logic [4:0]  mask_idx;
  logic [DW-1:0] got_q[$];
  int          rst_seen = 0, done_seen = 0, busy_late = 0, clash = 0;
  logic        done_prev = 1'b0;

  assign mask_idx  = 5'(wr_idx - wr_base);
  assign fifo_full = full_mask[mask_idx];
  assign lvl       = wr_idx[AW:0];

  // write index advances on the edge that completes a write, so fifo_full is stable through it
  always @(posedge clk) if (fifo_wr_en) wr_idx <= wr_idx + 1;

  always @(negedge clk) begin
    if (fifo_wr_en) got_q.push_back(fifo_wr_data);
    if (fifo_wr_rst) rst_seen++;
    if (fifo_wr_en && fifo_wr_rst) clash++;
    if (frame_done) done_seen++;
    if (done_prev && busy) busy_late++;
    done_prev = frame_done;
  end

  typedef struct {
    int          len;
    logic [31:0] mask;
    bit          gap;
    bit          repulse;
    int          exp_words;
    bit          exp_ovf;
    int          exp_drop;
    bit          exp_short;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [DW-1:0] dat(input int i);
    return 16'h0200 | 16'((i * 13 + 3) & 31);
  endfunction

  function automatic logic [DW-1:0] exp_word(input int k, input int len);
`ifdef FFT_FIFO_DECIM_EN
    logic [DW-1:0] a, b;
    a = dat(2 * k);
    if (2 * k + 1 < len) begin
      b = dat(2 * k + 1);
      if (b > a) a = b;
    end
    return a;
`else
    if (len < 0) return '0;
    return dat(k);
`endif
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_req();
    @(negedge clk) frame_req = 1'b1;
    @(negedge clk) frame_req = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit last, input bit gap_now, input bit req);
    if (gap_now) begin
      fft_valid = 1'b0;
      fft_last  = 1'b0;
      @(negedge clk);
    end
    fft_valid = 1'b1;
    fft_data  = d;
    fft_last  = last;
    frame_req = req;
    @(negedge clk);
    fft_valid = 1'b0;
    fft_last  = 1'b0;
    frame_req = 1'b0;
  endtask

  task automatic run_vec(input int v, input vec_t t);
    int q0, r0, d0, b0, c0, n, len;
    string tag;
    tag = $sformatf("v%0d", v);
    wr_base   = wr_idx;
    full_mask = t.mask;
    q0 = got_q.size(); r0 = rst_seen; d0 = done_seen; b0 = busy_late; c0 = clash;
    pulse_req();
    for (int f = 0; f < 3; f++) begin
      len = (f == 1) ? t.len : 16;
      for (int i = 0; i < len; i++)
        beat((f == 1) ? dat(i) : 16'(16'hE000 + f * 256 + i), i == len - 1,
             t.gap && (i % 3 == 2), t.repulse && f == 1 && i == 2);
    end
    for (int c = 0; c < 60 && busy; c++) @(negedge clk);
    full_mask = '0;
    chk({tag, "_busy_end"}, busy, 0);
    n = got_q.size() - q0;
    chk({tag, "_words"}, n, t.exp_words);
    for (int k = 0; k < n && k < t.exp_words; k++)
      chk($sformatf("%s_data%0d", tag, k), got_q[q0 + k], exp_word(k, t.len));
    chk({tag, "_rst_cycles"}, rst_seen - r0, RC);
    chk({tag, "_done_pulses"}, done_seen - d0, 1);
    chk({tag, "_busy_after_done"}, busy_late - b0, 0);
    chk({tag, "_wr_during_rst"}, clash - c0, 0);
    chk({tag, "_overflow"}, overflow, t.exp_ovf);
    chk({tag, "_drop_cnt"}, drop_cnt, t.exp_drop);
    chk({tag, "_short"}, short_frame, t.exp_short);
  endtask

  initial begin
    int q0;
`ifdef FFT_FIFO_DECIM_EN
    tbl[0] = '{16, 32'h0,  1'b0, 1'b0, 8, 1'b0, 0, 1'b0};
    tbl[1] = '{16, 32'h52, 1'b0, 1'b1, 8, 1'b1, 3, 1'b0};
    tbl[2] = '{5,  32'h0,  1'b0, 1'b0, 3, 1'b0, 0, 1'b1};
    tbl[3] = '{8,  32'h0,  1'b1, 1'b0, 4, 1'b0, 0, 1'b1};
    tbl[4] = '{3,  32'h1,  1'b1, 1'b0, 2, 1'b1, 1, 1'b1};
`else
    tbl[0] = '{16, 32'h0,  1'b0, 1'b0, 8, 1'b0, 0, 1'b0};
    tbl[1] = '{16, 32'h52, 1'b0, 1'b1, 8, 1'b1, 3, 1'b0};
    tbl[2] = '{5,  32'h0,  1'b0, 1'b0, 5, 1'b0, 0, 1'b1};
    tbl[3] = '{8,  32'h0,  1'b1, 1'b0, 8, 1'b0, 0, 1'b0};
    tbl[4] = '{3,  32'h1,  1'b1, 1'b0, 3, 1'b1, 1, 1'b1};
`endif
    rst_n = 1'b0; frame_req = 1'b0; fft_valid = 1'b0; fft_last = 1'b0; fft_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {fifo_wr_en, fifo_wr_rst, busy, frame_done, overflow, short_frame, drop_cnt, fifo_wr_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int v = 0; v < 5; v++) run_vec(v, tbl[v]);

    // abort mid-capture: one lost write first, then reset after three writes
    wr_base   = wr_idx;
    full_mask = 32'h1;
    q0 = got_q.size();
    pulse_req();
    for (int i = 0; i < 16; i++) beat(16'(16'hE000 + i), i == 15, 1'b0, 1'b0);
    for (int i = 0; i < 16 && (got_q.size() - q0) < 3; i++) beat(dat(i), 1'b0, 1'b0, 1'b0);
    chk("abort_writes_before_rst", got_q.size() - q0, 3);
    chk("abort_overflow_before_rst", overflow, 1);
    #2 rst_n = 1'b0;
    #1 chk("abort_outputs", {fifo_wr_en, fifo_wr_rst, busy, frame_done, overflow, short_frame, drop_cnt, fifo_wr_data}, 0);
    full_mask = '0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle", {busy, fifo_wr_en}, 0);
    run_vec(5, tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
